floor_scroll_ctrl: RTL and testbench

FLOOR_SCROLL_CTRL -- requirements
Module: floor_scroll_ctrl

---
 rtl/floor_scroll_ctrl.sv | 146 ++++++++++++++
 tb/tb_floor_scroll_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/floor_scroll_ctrl.sv
// Game-flow controller for a vertically scrolling floor field: run/pause/over FSM,
// frame-paced scroll steps, spawn handshake and LFSR spawn x.
// Optional speed-up levels enabled by defining FLOOR_SCROLL_SPEEDUP_EN.
module floor_scroll_ctrl #(
  parameter int unsigned SPAWN_GAP    = 60,
  parameter int unsigned LEVEL_FRAMES = 600,
  parameter int unsigned X_MIN        = 40,
  parameter int unsigned X_MAX        = 560
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       game_over,
  input  logic       spawn_ready,
  output logic [1:0] state,
  output logic       scroll_step,
  output logic       spawn_valid,
  output logic [2:0] spawn_slot,
  output logic [9:0] spawn_x,
  output logic [1:0] level
);

  localparam int unsigned DIV_W  = 2;
  localparam int unsigned DIST_W = 8;
  localparam int unsigned X_W    = 10;
  localparam int unsigned X_SPAN = X_MAX - X_MIN;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  if (SPAWN_GAP < 2 || SPAWN_GAP > 255 || LEVEL_FRAMES < 1 || LEVEL_FRAMES > 1023 ||
      X_MAX < X_MIN + 512 || X_MAX > X_MIN + 1022 || X_MAX > 1023) begin : g_param_check
    $error("floor_scroll_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q;
  logic [DIV_W-1:0]    div_q;
  logic [DIST_W-1:0]   dist_q;

  logic                fresh_run_c, abort_c, run_tick_c, step_c;
  logic                spawn_due_c, div_last_c;
  logic [DIV_W-1:0]    div_last_val_c;
  logic [X_W-1:0]      x_off_c, x_c;
  logic                lfsr_fb_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; game_over outranks pause
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (game_over) state_d = OVER;
               else if (pause) state_d = PAUSE;
      PAUSE:   if (game_over) state_d = OVER;
               else if (!pause) state_d = RUN;
      OVER:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;

  // A tick only advances the divider while we stay in RUN and no spawn is pending
  always_comb begin
    fresh_run_c    = start && (state_q == IDLE || state_q == OVER);
    abort_c        = game_over && (state_q == RUN || state_q == PAUSE);
    run_tick_c     = frame_tick && (state_q == RUN);
    spawn_due_c    = scroll_step && (dist_q == DIST_W'(SPAWN_GAP - 1));
    step_c         = run_tick_c && !game_over && !pause && !spawn_valid && !spawn_due_c;
    div_last_val_c = DIV_W'(3) - level;
    div_last_c     = (div_q >= div_last_val_c);
    lfsr_fb_c      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    x_off_c        = (lfsr_q[9:0] > X_W'(X_SPAN)) ? lfsr_q[9:0] - X_W'(X_SPAN + 1) : lfsr_q[9:0];
    x_c            = X_W'(X_MIN) + x_off_c;
  end

  // Scroll pacing, spawn handshake and slot rotation
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q      <= LFSR_SEED;
      div_q       <= '0;
      dist_q      <= '0;
      scroll_step <= 1'b0;
      spawn_valid <= 1'b0;
      spawn_slot  <= '0;
      spawn_x     <= X_W'(X_MIN);
    end else begin
      lfsr_q      <= {lfsr_q[14:0], lfsr_fb_c};
      scroll_step <= step_c && div_last_c;
      if (fresh_run_c) begin
        div_q       <= '0;
        dist_q      <= '0;
        spawn_valid <= 1'b0;
        spawn_slot  <= '0;
      end else if (abort_c) begin
        spawn_valid <= 1'b0;
      end else begin
        if (step_c) div_q <= div_last_c ? '0 : div_q + DIV_W'(1);
        if (scroll_step) dist_q <= spawn_due_c ? '0 : dist_q + DIST_W'(1);
        if (spawn_due_c) begin
          spawn_valid <= 1'b1;
          spawn_x     <= x_c;
        end else if (spawn_valid && spawn_ready) begin
          spawn_valid <= 1'b0;
          spawn_slot  <= spawn_slot + 3'd1;
        end
      end
    end
  end

`ifdef FLOOR_SCROLL_SPEEDUP_EN
  localparam int unsigned LVL_W = 10;
  logic [LVL_W-1:0] lvl_cnt_q;

  // Speed level: every LEVEL_FRAMES RUN ticks, stalls included, saturating at 3
  always_ff @(posedge clk) begin
    if (rst || fresh_run_c) begin
      lvl_cnt_q <= '0;
      level     <= 2'd0;
    end else if (run_tick_c) begin
      if (lvl_cnt_q == LVL_W'(LEVEL_FRAMES - 1)) begin
        lvl_cnt_q <= '0;
        if (level != 2'd3) level <= level + 2'd1;
      end else begin
        lvl_cnt_q <= lvl_cnt_q + LVL_W'(1);
      end
    end
  end
`else
  assign level = 2'd0;
`endif

endmodule

// File: tb/tb_floor_scroll_ctrl.sv
// Scoreboard bench for floor_scroll_ctrl (SPAWN_GAP=4, LEVEL_FRAMES=8); expectations
// follow FLOOR_SCROLL_SPEEDUP_EN if it is defined for the build.
module tb_floor_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0, start = 1'b0, pause = 1'b0, game_over = 1'b0, spawn_ready = 1'b0;
  logic [1:0] state;
  logic       scroll_step, spawn_valid;
  logic [2:0] spawn_slot;
  logic [9:0] spawn_x;
  logic [1:0] level;

  floor_scroll_ctrl #(.SPAWN_GAP(4), .LEVEL_FRAMES(8), .X_MIN(40), .X_MAX(560)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause),
    .game_over(game_over), .spawn_ready(spawn_ready), .state(state),
    .scroll_step(scroll_step), .spawn_valid(spawn_valid), .spawn_slot(spawn_slot),
    .spawn_x(spawn_x), .level(level)
  );

  always #5 clk = ~clk;

`ifdef FLOOR_SCROLL_SPEEDUP_EN
  localparam int          P1B_N = 6;
  localparam logic [31:0] P1B_S = 32'h24, P1B_P = 32'h20, P1C_S = 32'h0, P1C_P = 32'h0;
  localparam int          P2_N  = 8;
  localparam logic [31:0] P2_S  = 32'hAA, P2_P = 32'h80;
  localparam int          CYC_N = 4;
  localparam logic [31:0] CYC_S = 32'hF, CYC_P = 32'h8;
  localparam int          E_N   = 10;
  localparam logic [31:0] E_S   = 32'h248, E_P = 32'h200;
  localparam int          LVL_A = 1, LVL_C = 2, LVL_2 = 3;
`else
  localparam int          P1B_N = 6;
  localparam logic [31:0] P1B_S = 32'h8, P1B_P = 32'h0, P1C_S = 32'h2, P1C_P = 32'h2;
  localparam int          P2_N  = 16;
  localparam logic [31:0] P2_S  = 32'h8888, P2_P = 32'h8000;
  localparam int          CYC_N = 16;
  localparam logic [31:0] CYC_S = 32'h8888, CYC_P = 32'h8000;
  localparam int          E_N   = 12;
  localparam logic [31:0] E_S   = 32'h888, E_P = 32'h800;
  localparam int          LVL_A = 0, LVL_C = 0, LVL_2 = 0;
`endif

  typedef enum int {EV_STEP = 0, EV_SPAWN = 1, EV_DROP = 2} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cycle;
    int       slot;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         n_pass = 0, n_total = 0;
  int         exp_slot = 0;
  bit         mon_en = 1'b0;
  bit         prev_valid = 1'b0;
  logic [9:0] cap_x = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input ev_kind_t k, input int c, input int s);
    ev_t e;
    e.kind  = k;
    e.cycle = c;
    e.slot  = s;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input ev_kind_t k, input int slot);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: got kind %0d slot %0d, expected none (cycle %0d)", int'(k), slot, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", int'(k), int'(e.kind));
      chk("event_cycle", cyc, e.cycle);
      if (k != EV_STEP) chk("event_slot", slot, e.slot);
    end
  endtask

  // Monitor: every step, spawn rise and spawn drop must match the next expected event
  always @(negedge clk) begin
    if (mon_en) begin
      if (scroll_step) expect_ev(EV_STEP, 0);
      if (spawn_valid && !prev_valid) begin
        expect_ev(EV_SPAWN, int'(spawn_slot));
        chk("spawn_x_range", int'(spawn_x >= 10'd40 && spawn_x <= 10'd560), 1);
        cap_x = spawn_x;
      end else if (spawn_valid && prev_valid) begin
        chk("spawn_x_stable", int'(spawn_x), int'(cap_x));
      end
      if (!spawn_valid && prev_valid) expect_ev(EV_DROP, int'(spawn_slot));
      prev_valid = spawn_valid;
    end
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // n frames, each a tick edge then an idle edge; masks mark frames expected to step / spawn
  task automatic frames(input int n, input logic [31:0] smask, input logic [31:0] pmask);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tick_clk();
      frame_tick = 1'b0;
      if (smask[i]) push(EV_STEP, cyc, 0);
      if (pmask[i]) push(EV_SPAWN, cyc + 1, exp_slot);
      tick_clk();
    end
  endtask

  task automatic accept();
    spawn_ready = 1'b1;
    tick_clk();
    spawn_ready = 1'b0;
    exp_slot = (exp_slot + 1) % 8;
    push(EV_DROP, cyc, exp_slot);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick_clk();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick_clk();
    chk("rst_state", int'(state), 0);
    chk("rst_step", int'(scroll_step), 0);
    chk("rst_valid", int'(spawn_valid), 0);
    chk("rst_slot", int'(spawn_slot), 0);
    chk("rst_x", int'(spawn_x), 40);
    chk("rst_level", int'(level), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    frames(2, 32'h0, 32'h0);
    chk("idle_ignores_tick", int'(state), 0);
    do_start();
    chk("start_run", int'(state), 1);

    frames(8, 32'h88, 32'h0);
    chk("level_after_8", int'(level), LVL_A);
    frames(P1B_N, P1B_S, P1B_P);
    frames(2, P1C_S, P1C_P);
    chk("spawn_pending", int'(spawn_valid), 1);
    chk("first_slot", int'(spawn_slot), 0);
    chk("level_after_16", int'(level), LVL_C);
    accept();

    frames(P2_N, P2_S, P2_P);
    chk("level_after_24", int'(level), LVL_2);
    accept();
    for (int s = 0; s < 6; s++) begin
      frames(CYC_N, CYC_S, CYC_P);
      accept();
    end
    chk("slot_wrapped", int'(spawn_slot), 0);
    chk("level_saturated", int'(level), LVL_2);

    frames(CYC_N, CYC_S, CYC_P);
    accept();
    frames(CYC_N, CYC_S, CYC_P);
    pause = 1'b1;
    tick_clk();
    chk("pause_state", int'(state), 2);
    chk("pause_keeps_valid", int'(spawn_valid), 1);
    frames(3, 32'h0, 32'h0);
    pause = 1'b0;
    tick_clk();
    chk("resume_state", int'(state), 1);
    frames(2, 32'h0, 32'h0);
    pause = 1'b1;
    game_over = 1'b1;
    tick_clk();
    pause = 1'b0;
    game_over = 1'b0;
    push(EV_DROP, cyc, exp_slot);
    chk("over_beats_pause", int'(state), 3);
    tick_clk();
    chk("over_valid", int'(spawn_valid), 0);
    chk("over_slot_kept", int'(spawn_slot), 1);
    frames(3, 32'h0, 32'h0);

    do_start();
    exp_slot = 0;
    chk("restart_state", int'(state), 1);
    chk("restart_level", int'(level), 0);
    chk("restart_slot", int'(spawn_slot), 0);
    frames(4, 32'h8, 32'h0);
    frames(E_N, E_S, E_P);
    chk("pre_rst_valid", int'(spawn_valid), 1);

    rst = 1'b1;
    tick_clk();
    push(EV_DROP, cyc, 0);
    rst = 1'b0;
    chk("midrun_rst_state", int'(state), 0);
    chk("midrun_rst_valid", int'(spawn_valid), 0);
    chk("midrun_rst_slot", int'(spawn_slot), 0);
    chk("midrun_rst_x", int'(spawn_x), 40);
    chk("midrun_rst_level", int'(level), 0);
    frames(2, 32'h0, 32'h0);
    chk("post_rst_idle", int'(state), 0);

    repeat (4) tick_clk();
    chk("events_outstanding", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
